// File: rtl/mem_arb_pkg.sv
// Shared types for the N-channel memory-port arbiter.
package mem_arb_pkg;
  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} arb_state_e;
  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;
endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection: fixed priority from index 0, or rotating from rr_ptr.
module arb_pick #(
  parameter int N_CH = 2,
  parameter int IW   = $clog2(N_CH)
) (
  input  logic [N_CH-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  input  logic            mode,
  output logic [N_CH-1:0] winner,
  output logic [IW-1:0]   winner_idx
);
  int   base, k;
  logic found;

  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    k          = 0;
    base       = mode ? int'(rr_ptr) : 0;
    for (int i = 0; i < N_CH; i++) begin
      k = (base + i) % N_CH;
      if (!found && req[IW'(k)]) begin
        winner[IW'(k)] = 1'b1;
        winner_idx     = IW'(k);
        found          = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mem_arbiter.sv
// N-channel memory-port arbiter: one owner at a time, lockable bursts, optional watchdog.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ARB_MODE   = ARB_FIXED,
  parameter int TIMEOUT    = 0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [N_CH*ADDR_WIDTH-1:0]   i_ch_addr,
  input  logic [N_CH*DATA_WIDTH-1:0]   i_ch_data,
  input  logic [N_CH-1:0]              i_ch_wr_valid,
  output logic [N_CH-1:0]              o_ch_wr_ready,
  input  logic [N_CH-1:0]              i_ch_rd_ready,
  output logic [N_CH-1:0]              o_ch_rd_valid,
  output logic [DATA_WIDTH-1:0]        o_ch_data,
  input  logic [N_CH-1:0]              i_ch_lock,
  output logic [N_CH-1:0]              o_grant,
  output logic                         o_timeout,
  output logic [ADDR_WIDTH-1:0]        o_addr,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic                         o_wr_valid,
  input  logic                         i_wr_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  input  logic                         i_rd_valid,
  output logic                         o_rd_ready
);
  localparam int IW = $clog2(N_CH);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_e state, state_nx;
  logic [N_CH-1:0] req, pick, grant_nx;
  logic [IW-1:0]   pick_idx, gidx, gidx_nx, rr_ptr, rr_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  logic            own, cmpl, wd_hit, rel;
  logic [N_CH-1:0][ADDR_WIDTH-1:0] addr_v;
  logic [N_CH-1:0][DATA_WIDTH-1:0] data_v;

  assign req    = i_ch_wr_valid | i_ch_rd_ready;
  assign own    = (state == OWN);
  assign addr_v = i_ch_addr;
  assign data_v = i_ch_data;

  arb_pick #(.N_CH(N_CH), .IW(IW)) u_pick (
    .req(req), .rr_ptr(rr_ptr), .mode(ARB_MODE == ARB_RR),
    .winner(pick), .winner_idx(pick_idx)
  );

  // Channel <-> memory muxing is purely combinational on the registered owner.
  always_comb begin
    o_addr        = '0;
    o_data        = '0;
    o_wr_valid    = 1'b0;
    o_rd_ready    = 1'b0;
    o_ch_wr_ready = '0;
    o_ch_rd_valid = '0;
    o_ch_data     = '0;
    if (own) begin
      o_addr              = addr_v[gidx];
      o_data              = data_v[gidx];
      o_wr_valid          = i_ch_wr_valid[gidx];
      o_rd_ready          = !i_ch_wr_valid[gidx] && i_ch_rd_ready[gidx];
      o_ch_wr_ready[gidx] = i_wr_ready && o_wr_valid;
      o_ch_rd_valid[gidx] = i_rd_valid && o_rd_ready;
      o_ch_data           = i_data;
    end
  end

  assign cmpl      = (o_wr_valid && i_wr_ready) || (o_rd_ready && i_rd_valid);
  assign wd_hit    = own && (TIMEOUT > 0) && (cnt == CW'(TIMEOUT));
  assign o_timeout = wd_hit;
  assign rel       = own && (wd_hit || (!i_ch_lock[gidx] && (cmpl || !req[gidx])));

  always_comb begin
    state_nx = state;
    grant_nx = o_grant;
    gidx_nx  = gidx;
    rr_nx    = rr_ptr;
    cnt_nx   = '0;
    case (state)
      IDLE: if (|req) begin
        state_nx = OWN;
        grant_nx = pick;
        gidx_nx  = pick_idx;
      end
      OWN: begin
        if (!cmpl && cnt != CW'(TIMEOUT)) cnt_nx = cnt + 1'b1;
        if (rel) begin
          state_nx = IDLE;
          grant_nx = '0;
          cnt_nx   = '0;
          if (ARB_MODE == ARB_RR)
            rr_nx = (gidx == IW'(N_CH - 1)) ? '0 : gidx + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      o_grant <= '0;
      gidx    <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_nx;
      o_grant <= grant_nx;
      gidx    <= gidx_nx;
      rr_ptr  <= rr_nx;
      cnt     <= cnt_nx;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, round-robin sequence, randomized model compare.
module tb_mem_arbiter;
  localparam int N = 3, AW = 32, DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [N*AW-1:0] ch_addr;
  logic [N*DW-1:0] ch_data;
  logic [N-1:0]    wr, rd, lock;
  logic            wrdy, rdv;
  logic [DW-1:0]   mdata;

  logic [N-1:0]  g_o[2], chwr_o[2], chrv_o[2];
  logic [DW-1:0] chd_o[2], mdat_o[2];
  logic [AW-1:0] addr_o[2];
  logic          to_o[2], wv_o[2], rr_o[2];

  // dut0: fixed priority with watchdog; dut1: round-robin, watchdog off
  mem_arbiter #(.N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(0), .TIMEOUT(5)) dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_addr(ch_addr), .i_ch_data(ch_data),
    .i_ch_wr_valid(wr), .o_ch_wr_ready(chwr_o[0]), .i_ch_rd_ready(rd), .o_ch_rd_valid(chrv_o[0]),
    .o_ch_data(chd_o[0]), .i_ch_lock(lock), .o_grant(g_o[0]), .o_timeout(to_o[0]),
    .o_addr(addr_o[0]), .o_data(mdat_o[0]), .o_wr_valid(wv_o[0]), .i_wr_ready(wrdy),
    .i_data(mdata), .i_rd_valid(rdv), .o_rd_ready(rr_o[0]));

  mem_arbiter #(.N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ARB_MODE(1), .TIMEOUT(0)) dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_ch_addr(ch_addr), .i_ch_data(ch_data),
    .i_ch_wr_valid(wr), .o_ch_wr_ready(chwr_o[1]), .i_ch_rd_ready(rd), .o_ch_rd_valid(chrv_o[1]),
    .o_ch_data(chd_o[1]), .i_ch_lock(lock), .o_grant(g_o[1]), .o_timeout(to_o[1]),
    .o_addr(addr_o[1]), .o_data(mdat_o[1]), .o_wr_valid(wv_o[1]), .i_wr_ready(wrdy),
    .i_data(mdata), .i_rd_valid(rdv), .o_rd_ready(rr_o[1]));

  int errors = 0, checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic rst_n; logic [2:0] wr, rd, lock; logic wrdy, rdv;
    logic [2:0] g; logic wv, rr, to; logic [2:0] chrv, chwr; logic [31:0] addr;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mkv(input int r, w, d, l, wy, rv, g, wv, rr, to, crv, cwr, a);
    vec_t v;
    v.rst_n = 1'(r); v.wr = 3'(w); v.rd = 3'(d); v.lock = 3'(l); v.wrdy = 1'(wy); v.rdv = 1'(rv);
    v.g = 3'(g); v.wv = 1'(wv); v.rr = 1'(rr); v.to = 1'(to); v.chrv = 3'(crv); v.chwr = 3'(cwr);
    v.addr = 32'(a);
    return v;
  endfunction

  function automatic logic bt(input logic [2:0] v, input int i);
    return |(v & (3'd1 << i));
  endfunction

  // Reference model state: owner (-1 = none), round-robin start, stall counter
  int own[2], rrp[2], cnt[2];

  task automatic model_cycle(input int m, input int cyc);
    int g, tmo, start;
    logic md, ewv, err, eto, cmp;
    logic [2:0] eg, erv, ewr, rq;
    logic [31:0] ea, ed, ecd;
    md = (m == 1); tmo = (m == 0) ? 5 : 0; g = own[m];
    eg = 0; ewv = 0; err = 0; eto = 0; erv = 0; ewr = 0; ea = 0; ed = 0; ecd = 0; cmp = 0;
    rq = wr | rd;
    if (g >= 0) begin
      eg  = 3'd1 << g;
      ewv = bt(wr, g);
      err = !ewv && bt(rd, g);
      ea  = AW'(ch_addr >> (g * AW));
      ed  = DW'(ch_data >> (g * DW));
      ecd = mdata;
      if (ewv && wrdy) ewr = eg;
      if (err && rdv)  erv = eg;
      cmp = (ewr != 0) || (erv != 0);
      eto = (tmo > 0) && (cnt[m] == tmo);
    end
    check($sformatf("rand%0d.dut%0d", cyc, m),
          128'({g_o[m], wv_o[m], rr_o[m], to_o[m], chrv_o[m], chwr_o[m], addr_o[m], mdat_o[m], chd_o[m]}),
          128'({eg, ewv, err, eto, erv, ewr, ea, ed, ecd}));
    if (g < 0) begin
      if (rq != 0) begin
        start = md ? rrp[m] : 0;
        for (int i = 0; i < N; i++)
          if (own[m] < 0 && bt(rq, (start + i) % N)) own[m] = (start + i) % N;
        cnt[m] = 0;
      end
    end else if (eto || (!bt(lock, g) && (cmp || !bt(rq, g)))) begin
      own[m] = -1; cnt[m] = 0;
      if (md) rrp[m] = (g + 1) % N;
    end else begin
      cnt[m] = cmp ? 0 : cnt[m] + 1;
    end
  endtask

  function automatic int oh_idx(input logic [2:0] v);
    case (v)
      3'b001:  return 0;
      3'b010:  return 1;
      3'b100:  return 2;
      default: return 9;
    endcase
  endfunction

  initial begin
    int seen[$];
    rst_n = 1'b0; wr = '0; rd = '0; lock = '0; wrdy = 1'b0; rdv = 1'b0;
    mdata = 32'hDEADBEEF;
    ch_addr = {32'h300, 32'h200, 32'h100};
    ch_data = {32'hA2, 32'hA1, 32'hA0};

    //            rst wr rd lk wy rv   g wv rr to crv cwr addr
    tbl.push_back(mkv(0, 7, 7, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));       // reset, all requesting
    tbl.push_back(mkv(1, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 6, 0, 0, 1, 2, 0, 1, 0, 2, 0, 'h200));   // ch1 beats ch2
    tbl.push_back(mkv(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 4, 0, 0, 1, 4, 0, 1, 0, 4, 0, 'h300));
    tbl.push_back(mkv(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 1, 1, 0, 1, 0, 1, 1, 0, 0, 0, 1, 'h100));   // write wins over read
    tbl.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 0, 1, 1, 0, 1, 0, 1, 0, 'h100));
    tbl.push_back(mkv(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mkv(1, 0, 3, 1, 0, 1, 1, 0, 1, 0, 1, 0, 'h100)); // locked beats
    tbl.push_back(mkv(1, 0, 3, 0, 0, 1, 1, 0, 1, 0, 1, 0, 'h100));   // final beat
    tbl.push_back(mkv(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 2, 0, 0, 1, 2, 0, 1, 0, 2, 0, 'h200));
    tbl.push_back(mkv(1, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mkv(1, 0, 3, 1, 0, 0, 1, 0, 1, 0, 0, 0, 'h100)); // stalled
    tbl.push_back(mkv(1, 0, 3, 1, 0, 0, 1, 0, 1, 1, 0, 0, 'h100));   // watchdog fires
    tbl.push_back(mkv(1, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 2, 0, 0, 1, 2, 0, 1, 0, 2, 0, 'h200));
    tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mkv(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));       // reset mid-grant
    tbl.push_back(mkv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      rst_n = tbl[i].rst_n; wr = tbl[i].wr; rd = tbl[i].rd; lock = tbl[i].lock;
      wrdy = tbl[i].wrdy; rdv = tbl[i].rdv;
      #1;
      check($sformatf("vec%0d", i),
            128'({g_o[0], wv_o[0], rr_o[0], to_o[0], chrv_o[0], chwr_o[0], addr_o[0]}),
            128'({tbl[i].g, tbl[i].wv, tbl[i].rr, tbl[i].to, tbl[i].chrv, tbl[i].chwr, tbl[i].addr}));
      if (tbl[i].chrv != 0)
        check($sformatf("vec%0d.rdata", i), 128'(chd_o[0]), 128'(32'hDEADBEEF));
    end

    // Round-robin: all channels reading, memory always ready
    @(negedge clk); rst_n = 1'b0; wr = '0; rd = 3'b111; lock = '0; wrdy = 1'b0; rdv = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 20 && seen.size() < 6; c++) begin
      @(posedge clk); #1;
      if (g_o[1] != 0) seen.push_back(oh_idx(g_o[1]));
    end
    check("rr.count", 128'(seen.size()), 128'(6));
    foreach (seen[k]) check($sformatf("rr.order%0d", k), 128'(seen[k]), 128'(k % 3));

    // Randomized traffic against the reference model
    @(negedge clk); rst_n = 1'b0; wr = '0; rd = '0; lock = '0; wrdy = 1'b0; rdv = 1'b0;
    for (int m = 0; m < 2; m++) begin own[m] = -1; rrp[m] = 0; cnt[m] = 0; end
    @(negedge clk); rst_n = 1'b1;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      wr = 3'($urandom); rd = 3'($urandom); lock = 3'($urandom) & 3'($urandom);
      wrdy = 1'($urandom); rdv = 1'($urandom); mdata = $urandom;
      ch_addr = {$urandom, $urandom, $urandom};
      ch_data = {$urandom, $urandom, $urandom};
      #1;
      model_cycle(0, cyc);
      model_cycle(1, cyc);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel memory-port arbiter. It generalises the core's state-selected address and data multiplexer, which is hardwired to two clients (fetch, execute). Up to N_CH masters request the single memory port. Each master uses the core's read/write handshake, and the arbiter grants the port to one channel at a time. Arbitration mode, lock-based bursts and a watchdog timeout are selectable. It sits between the core's fetch/execute/future LSU units and the memory interface.

## Interface
- N_CH, 2: number of client channels (2..8); channel index 0..N_CH-1.
- ADDR_WIDTH, 32: address width.
- DATA_WIDTH, `DATA_WIDTH: data width.
- ARB_MODE, 0: 0 = fixed priority (channel 0 highest); 1 = round-robin.
- TIMEOUT, 0: max cycles a grant may stall without a handshake; 0 disables the watchdog.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- i_ch_addr  in  N_CH*ADDR_WIDTH  per-channel address, channel k at bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- i_ch_data  in  N_CH*DATA_WIDTH  per-channel write data.
- i_ch_wr_valid  in  N_CH  write request.
- o_ch_wr_ready  out  N_CH  write accepted.
- i_ch_rd_ready  in  N_CH  read request.
- o_ch_rd_valid  out  N_CH  read data valid.
- o_ch_data  out  DATA_WIDTH  read data, shared by all channels; meaningful only with o_ch_rd_valid[k].
- i_ch_lock  in  N_CH  hold the grant after completion (multi-beat sequences).
- o_grant  out  N_CH  one-hot owner, or all zero.
- o_timeout  out  1  one-cycle pulse when the watchdog revokes a grant.
- o_addr  out  ADDR_WIDTH  memory address.
- o_data  out  DATA_WIDTH  memory write data.
- o_wr_valid  out  1  memory write request.
- i_wr_ready  in  1  memory write accept.
- i_data  in  DATA_WIDTH  memory read data.
- i_rd_valid  in  1  memory read data valid.
- o_rd_ready  out  1  memory read request.

## Operation
- Request from channel k: req[k] = i_ch_wr_valid[k] | i_ch_rd_ready[k].
- Completion: a write completes when o_wr_valid & i_wr_ready; a read completes when o_rd_ready & i_rd_valid.
- States: IDLE, OWN.
- IDLE
  - All memory outputs are 0 and all channel outputs are 0.
  - If any req is set, pick a winner, register it into o_grant, and go to OWN.
- Winner selection
  - ARB_MODE 0: the lowest requesting index wins.
  - ARB_MODE 1: the first requesting index at or after rr_ptr (wrapping) wins.
- OWN, owner g
  - o_addr/o_data come from channel g.
  - If i_ch_wr_valid[g] is set: o_wr_valid = 1, o_rd_ready = 0. A write wins over a read from the same channel.
  - Otherwise: o_rd_ready = i_ch_rd_ready[g].
  - i_wr_ready/i_rd_valid/i_data are routed back only to channel g; other channels see 0.
- Release to IDLE at the clock edge, when either:
  - a completion occurs and i_ch_lock[g] = 0; or
  - req[g] = 0 and i_ch_lock[g] = 0, which is an abort.
- While i_ch_lock[g] = 1, the arbiter stays in OWN regardless of completions or req.
- On release in mode 1, rr_ptr <= (g+1) mod N_CH, wrapping N_CH-1 to 0. In mode 0, rr_ptr is unused.
- Watchdog (TIMEOUT > 0)
  - A counter clears on entering OWN and on every completion, and increments otherwise.
  - When it reaches TIMEOUT: o_timeout = 1 for that cycle, the grant is released unconditionally (lock ignored) and the state goes to IDLE.
  - rr_ptr advances as for a normal release.
- Counter width is $clog2(TIMEOUT+1). The counter saturates and never wraps.

## Timing
- Reset (asynchronous, i_rst_n = 0): state IDLE, o_grant 0, rr_ptr 0, counter 0, o_timeout 0. All memory and channel outputs read 0.
- Arbitration latency: a request in cycle t gives o_grant set at t+1, and the memory request is visible at t+1. A completion is possible at t+1.
- Back-to-back transactions:
  - With lock held: one completion per cycle, no IDLE bubble.
  - Without lock: at least one IDLE cycle between owners (minimum 2 cycles per transaction).
- Data path muxing in OWN is combinational: memory to channel and channel to memory, zero cycles.
- Reset asserted mid-transaction: the grant drops immediately and memory requests fall to 0 asynchronously. Any in-flight transaction is lost.
- A new request arriving while another channel owns the port waits. It is never pre-empted except by timeout.
- The requester's address/data must stay stable until completion. The arbiter does not latch them.

## Structure
- Package mem_arb_pkg:
  - state enum (IDLE, OWN);
  - ARB_FIXED/ARB_RR localparams.
- Sub-module arb_pick: combinational, inputs req[N_CH], rr_ptr, mode; output one-hot winner.
- mem_arbiter holds the state register, grant, rr_ptr, watchdog and the data muxes.

## Test plan
- Reset: hold i_rst_n = 0 with all requests high → o_grant = 0, o_wr_valid = o_rd_ready = 0, o_timeout = 0.
- Fixed priority: N_CH = 3; channels 1 and 2 request a read at once, memory returns i_rd_valid with i_data = 0xDEADBEEF → channel 1 is granted and gets o_ch_rd_valid[1] with 0xDEADBEEF, then channel 2 is served.
- Round-robin fairness: ARB_MODE = 1; all 3 channels request continuously, each completing in 1 cycle → grant order 0, 1, 2, 0, 1, 2.
- Write priority: channel 0 asserts wr_valid and rd_ready together with addr 0x100 → o_wr_valid = 1, o_rd_ready = 0, o_addr = 0x100; the read is served after the write completes.
- Lock: channel 0 holds lock for 4 reads while channel 1 requests → channel 1 is granted only after the lock drops and channel 0's final completion.
- Watchdog: TIMEOUT = 5; channel 0 requests a read with memory stalled → o_timeout pulses 5 cycles after the grant, the grant goes to 0, and a pending channel 1 is granted in the following arbitration cycle.
